// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a shadowed display value.
// New values reach the display only at frame boundaries, so no frame mixes old and new digits.
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  dp_in,
  output logic        upd_pending,
  output logic [3:0]  segan_en,
  output logic [7:0]  segans
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic [3:0]    segan_en_q, segan_en_d;
  logic [7:0]    segans_q, segans_d;

  logic        slot_end;
  logic        commit;
  logic [3:0]  nibble;
  logic [15:0] upper;
  logic        blanked;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign slot_end = (cnt_q == CNT_LAST);
  assign commit   = slot_end && (dig_q == 2'd3);

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    dig_d      = slot_end ? dig_q + 2'd1 : dig_q;
    disp_d     = disp_q;
    shadow_d   = wr_en ? wr_data : shadow_q;
    pend_d     = pend_q;
    if (commit) begin
      // A write landing on the commit cycle bypasses the shadow entirely.
      if (wr_en) begin
        disp_d = wr_data;
      end else if (pend_q) begin
        disp_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (wr_en) begin
      pend_d = 1'b1;
    end

    nibble  = disp_q[{dig_q, 2'b00} +: 4];
    upper   = disp_q >> {dig_q, 2'b00};
    blanked = (BLANK_LZ != 0) && (dig_q != 2'd0) && (upper == 16'h0000);

    // The last cycle of each slot is dark to avoid ghosting on the next digit.
    segan_en_d = (slot_end || blanked) ? 4'b0000 : (4'b0001 << dig_q);
    segans_d   = {dp_in[dig_q], hex_to_seg(nibble)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      disp_q     <= 16'h0000;
      shadow_q   <= 16'h0000;
      pend_q     <= 1'b0;
      segan_en_q <= 4'b0000;
      segans_q   <= 8'h00;
    end else begin
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      segan_en_q <= segan_en_d;
      segans_q   <= segans_d;
    end
  end

  assign upd_pending = pend_q;
  assign segan_en    = segan_en_q;
  assign segans      = segans_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (blanking on/off) compared cycle by cycle
// against a frame-position model built from cycle counts since reset.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  dp_in;
  logic        upd_b, upd_n;
  logic [3:0]  en_b, en_n;
  logic [7:0]  seg_b, seg_n;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut_blank (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .dp_in(dp_in),
    .upd_pending(upd_b), .segan_en(en_b), .segans(seg_b)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut_full (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .dp_in(dp_in),
    .upd_pending(upd_n), .segan_en(en_n), .segans(seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: cycles elapsed since reset plus the committed/buffered values.
  int          model_n;
  logic [15:0] disp_m, shadow_m;
  logic        pend_m;
  logic [25:0] exp_vec;
  logic [25:0] obs;
  int          checks, passed;

  assign obs = {en_b, en_n, seg_b, seg_n, upd_b, upd_n};

  // Advance one clock: predict the outputs from the model and current inputs, then update the model.
  task automatic tick();
    int          pos, slot;
    logic [15:0] upper;
    logic [3:0]  nib, onehot, eb, en;
    logic [7:0]  es;
    logic        lit;
    int          nn;
    logic [15:0] nd, ns;
    logic        np;
    if (reset) begin
      eb = 4'h0; en = 4'h0; es = 8'h00;
      nn = 0; nd = 16'h0; ns = 16'h0; np = 1'b0;
    end else begin
      pos    = model_n % SD;
      slot   = (model_n / SD) % 4;
      upper  = disp_m >> (4 * slot);
      nib    = upper[3:0];
      onehot = 4'b0001 << slot;
      lit    = (pos != SD - 1);
      es     = {dp_in[slot], seg_tab[nib]};
      en     = lit ? onehot : 4'h0;
      eb     = (lit && (slot == 0 || upper != 16'h0)) ? onehot : 4'h0;
      nn = model_n + 1;
      nd = disp_m; ns = shadow_m; np = pend_m;
      if (wr_en) ns = wr_data;
      if (pos == SD - 1 && slot == 3) begin
        if (wr_en) nd = wr_data;
        else if (pend_m) nd = shadow_m;
        np = 1'b0;
      end else if (wr_en) begin
        np = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    model_n  = nn;
    disp_m   = nd;
    shadow_m = ns;
    pend_m   = np;
    exp_vec  = {eb, en, es, es, np, np};
  endtask

  task automatic align(input int phase);
    for (int k = 0; k < FRAME && (model_n % FRAME) != phase; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 26'h0) $display("[TB] FAIL reset_hold cyc%0d got %h expected %h", i, obs, 26'h0);
      else passed++;
    end
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL idle cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      checks++;
      if (en_b !== ((i < 3) ? 4'b0001 : 4'b0000) || (i < 3 && seg_b !== 8'h3F))
        $display("[TB] FAIL idle_pattern cyc%0d got en=%b seg=%h", i, en_b, seg_b);
      else passed++;
    end
  endtask

  task automatic test_full_value();
    align(0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      wr_en = (i == 1); wr_data = 16'h12AF;
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL full_value cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_blanking();
    align(0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      wr_en = (i == 1); wr_data = 16'h00C0;
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL blank_00C0 cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
    end
    align(0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      wr_en = (i == 1); wr_data = 16'h0000;
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL blank_0000 cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      if (i >= FRAME) begin
        checks++;
        if (en_b !== 4'b0000 && en_b !== 4'b0001) $display("[TB] FAIL blank_only_d0 got %b expected 0001/0000", en_b);
        else passed++;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_frame_atomic();
    align(0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      wr_en = (i == 5 || i == 9);
      wr_data = (i == 5) ? 16'h1111 : 16'h2222;
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL atomic cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      checks++;
      if (upd_b !== (i >= 5 && i < 15)) $display("[TB] FAIL atomic_pending cyc%0d got %b expected %b", i, upd_b, (i >= 5 && i < 15));
      else passed++;
      checks++;
      if (en_n != 4'h0 && seg_n[6:0] === 7'h06) $display("[TB] FAIL atomic_no_1111 cyc%0d got %h expected not 06", i, seg_n);
      else passed++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_commit_collision();
    align(FRAME - 1);
    for (int i = 0; i < FRAME + 4; i++) begin
      wr_en = (i == 0); wr_data = 16'h3333;
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL collision cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      checks++;
      if (upd_b !== 1'b0) $display("[TB] FAIL collision_pending cyc%0d got %b expected 0", i, upd_b);
      else passed++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_dp_and_reset();
    dp_in = 4'b0100;
    align(0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL dp cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      if (en_n != 4'h0) begin
        checks++;
        if (seg_n[7] !== en_n[2]) $display("[TB] FAIL dp_digit2 cyc%0d got %b expected %b", i, seg_n[7], en_n[2]);
        else passed++;
      end
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      wr_en = (i == 2); wr_data = 16'hFFFF;
      reset = (i == 6);
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL reset_pending cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
      checks++;
      if ((en_b != 4'h0 && seg_b[6:0] === 7'h71) || (i >= 6 && upd_b !== 1'b0))
        $display("[TB] FAIL reset_discard cyc%0d got seg=%h upd=%b", i, seg_b, upd_b);
      else passed++;
    end
    wr_en = 1'b0; reset = 1'b0; dp_in = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (obs !== exp_vec) $display("[TB] FAIL random cyc%0d got %h expected %h", i, obs, exp_vec);
      else passed++;
    end
    wr_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0;
    model_n = 0; disp_m = 16'h0; shadow_m = 16'h0; pend_m = 1'b0; exp_vec = '0;
    reset = 1'b1; wr_en = 1'b0; wr_data = 16'h0; dp_in = 4'b0000;
    test_reset();
    test_full_value();
    test_blanking();
    test_frame_atomic();
    test_commit_collision();
    test_dp_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Four-digit multiplexed seven-segment display driver inside `cpu_top`; sources the `segan_en`/`segans` pins. Accepts 16-bit hex values from the CPU-side display register write path and scans them one digit at a time. New values are committed only at frame boundaries, so a frame never mixes old and new digits. Optional leading-zero blanking and per-digit decimal points.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- `BLANK_LZ`, default 1: 1 = blank leading zero digits; 0 = always show all four.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous and active-high; one clock.
- `wr_en`  in  1  write strobe; single-cycle pulse; may be held.
- `wr_data`  in  16  hex value; nibble k drives digit k (digit 0 = `[3:0]`, rightmost).
- `dp_in`  in  4  decimal point per digit; sampled live, not shadowed.
- `upd_pending`  out  1  shadow holds a write not yet committed to the display.
- `segan_en`  out  4  digit enables, one-hot active-high, bit k = digit k.
- `segans`  out  8  segments active-high, `{dp,g,f,e,d,c,b,a}`.

## Operation
- State:
  - `cnt` counts 0..SCAN_DIV-1; wraps to 0.
  - `dig` is a 2-bit digit index; increments when `cnt==SCAN_DIV-1`, wraps 3→0.
  - `disp`: 16-bit committed value.
  - `shadow`: 16-bit write buffer.
  - `pend`: drives `upd_pending`.
- Write: `wr_en=1` loads `shadow<=wr_data` and sets `pend`. The last write before commit wins; no backpressure.
- Commit point: the cycle with `dig==3 && cnt==SCAN_DIV-1`.
  - `disp<=shadow` if `pend`, then `pend<=0`.
  - `wr_en` in the commit cycle commits `wr_data` directly and leaves `pend=0`.
- Ghost gap: when `cnt==SCAN_DIV-1`, the next `segan_en` is 4'b0000 (one dark cycle per slot).
- Blanking (`BLANK_LZ=1`):
  - Digit k≥1 is dark when nibbles k..3 of `disp` are all zero.
  - Digit 0 is never blanked.
  - A blanked digit has `segan_en` bit 0, but `segans` still carries its pattern.
- Decode, hex to `segans[6:0]`: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. `segans[7]=dp_in[dig]`.
- No other states. The scan free-runs from reset and never stalls.

## Timing
- Reset values: `cnt=0`, `dig=0`, `disp=0`, `shadow=0`, `pend=0`, `segan_en=4'b0000`, `segans=8'h00`, `upd_pending=0`.
- `segan_en` and `segans` are registered. The outputs in cycle t+1 reflect `cnt`, `dig`, `disp`, `dp_in` in cycle t.
  - The first edge after reset release presents digit 0 (`segan_en=0001`, `segans=3F`).
- Slot: SCAN_DIV cycles long: SCAN_DIV-1 lit, then 1 dark. Frame = 4·SCAN_DIV cycles.
- Write latency to display:
  - `upd_pending` rises the cycle after `wr_en`.
  - It falls the cycle after the commit point.
  - New digit 0 appears on the first slot after commit.
  - Worst case ≈ 4·SCAN_DIV+1 cycles.
- Reset mid-frame or mid-pending returns everything to reset values next edge. The pending write is discarded.
- `dp_in` changes take effect with one-cycle latency, even mid-slot.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset/idle:
  - Stimulus: hold reset 3 cycles, release, run 16 cycles.
  - Required: outputs 0 during reset.
  - Required: `segan_en` pattern 0001×3,0000, then 0000 for slots 1–3 (blanked). `segans=3F` during lit cycles.
- Full value, `BLANK_LZ=0`:
  - Stimulus: write 16'h12AF; wait for commit.
  - Required: next frame shows 0001/`71`, 0010/`77`, 0100/`5B`, 1000/`06`, each lit 3 cycles with a dark cycle after each.
- Blanking:
  - Stimulus: write 16'h00C0 with `BLANK_LZ=1`.
  - Required: digits 0,1 lit (`3F`, `39`); digits 2,3 have `segan_en=0000`.
  - Stimulus: write 16'h0000.
  - Required: only digit 0 lit with `3F`.
- Frame-atomic commit:
  - Stimulus: write 16'h1111 mid-digit-1, then 16'h2222 mid-digit-2.
  - Required: `upd_pending=1` until after the commit point. The current frame still shows the old value. The next frame shows all `5B`; `1111` never appears.
- Commit-cycle collision:
  - Stimulus: `wr_en` with 16'h3333 exactly at the `dig==3,cnt==3` cycle.
  - Required: the next frame shows `4F` on every digit and `upd_pending` stays 0.
- Decimal point and reset mid-pending:
  - Stimulus: `dp_in=4'b0100`.
  - Required: `segans[7]=1` only while digit 2 is scanned.
  - Stimulus: write 16'hFFFF, then assert reset before commit.
  - Required: `upd_pending=0`, display reverts to `3F` on digit 0; `FFFF` is never shown.
